// File: rtl/ivector_requester.sv
// Traffic source and in-order scoreboard for the IVector echo path: issues a numbered run of
// 96-bit say requests and checks each echoed indication against the same numbered pattern.
module ivector_requester #(
    parameter int          MAX_OUT = 4,
    parameter int          CNT_W   = 16,
    parameter logic [31:0] SALT    = 32'hA5A5_0F0F,
    parameter int          TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start__ENA,
    input  logic [CNT_W-1:0] start_count,
    output logic             start__RDY,
    output logic             request_say__ENA,
    output logic [95:0]      request_say_v,
    input  logic             request_say__RDY,
    input  logic             ind_heard__ENA,
    input  logic [95:0]      ind_heard_v,
    output logic             ind_heard__RDY,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [95:0]      first_fail_v
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int INF_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   sent_reg;
    logic [CNT_W-1:0]   recv_reg;
    logic [INF_W-1:0]   inflight_reg;
    logic [TMR_W-1:0]   timer_reg;

    logic               active;
    logic               issue;
    logic               heard;
    logic               match;
    logic [CNT_W-1:0]   recv_next;
    logic               last_heard;
    logic               timer_hit;
    logic [95:0]        expected_v;

    // Sequence number n becomes {~n, n^SALT, n}, n zero-extended to 32 bits.
    function automatic logic [95:0] pattern(input logic [CNT_W-1:0] n);
        logic [31:0] w;
        w = 32'(n);
        return {~w, w ^ SALT, w};
    endfunction

    assign active     = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign start__RDY = (state_reg == S_IDLE) || (state_reg == S_DONE);

    assign issue = (state_reg == S_RUN)
                && (sent_reg < count_reg)
                && (inflight_reg < INF_W'(MAX_OUT))
                && request_say__RDY;

    assign request_say__ENA = issue;
    // Payload is zero whenever no request is being issued, so reset drives it low too.
    assign request_say_v    = issue ? pattern(sent_reg) : '0;

    assign ind_heard__RDY = (inflight_reg != '0) && active;
    assign heard          = ind_heard__ENA && ind_heard__RDY;

    assign expected_v = pattern(recv_reg);
    assign match      = (ind_heard_v == expected_v);
    assign recv_next  = recv_reg + 1'b1;
    assign last_heard = heard && (recv_next == count_reg);

    // Abort fires on the cycle that would take the idle timer up to TIMEOUT.
    assign timer_hit = !heard && !issue && (inflight_reg != '0)
                    && (timer_reg == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            sent_reg     <= '0;
            recv_reg     <= '0;
            inflight_reg <= '0;
            timer_reg    <= '0;
            done         <= 1'b0;
            timed_out    <= 1'b0;
            pass_count   <= '0;
            fail_count   <= '0;
            first_fail_v <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start__ENA) begin
                        count_reg    <= start_count;
                        sent_reg     <= '0;
                        recv_reg     <= '0;
                        inflight_reg <= '0;
                        timer_reg    <= '0;
                        pass_count   <= '0;
                        fail_count   <= '0;
                        timed_out    <= 1'b0;
                        if (start_count == '0) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= S_RUN;
                            done      <= 1'b0;
                        end
                    end
                end

                S_RUN, S_DRAIN: begin
                    if (issue) begin
                        sent_reg <= sent_reg + 1'b1;
                    end

                    if (heard) begin
                        recv_reg <= recv_next;
                        if (match) begin
                            if (pass_count != '1) begin
                                pass_count <= pass_count + 1'b1;
                            end
                        end else begin
                            if (fail_count != '1) begin
                                fail_count <= fail_count + 1'b1;
                            end
                            // fail_count is cleared at start, so zero means first mismatch of this run.
                            if (fail_count == '0) begin
                                first_fail_v <= ind_heard_v;
                            end
                        end
                    end

                    case ({issue, heard})
                        2'b10:   inflight_reg <= inflight_reg + 1'b1;
                        2'b01:   inflight_reg <= inflight_reg - 1'b1;
                        default: inflight_reg <= inflight_reg;
                    endcase

                    if (issue || heard) begin
                        timer_reg <= '0;
                    end else if (inflight_reg != '0) begin
                        timer_reg <= timer_reg + 1'b1;
                    end

                    if (last_heard) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                    end else if (timer_hit) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                    end else if ((state_reg == S_RUN) && (sent_reg == count_reg)) begin
                        state_reg <= S_DRAIN;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
